// File: rtl/proc_memory.sv
// Instruction/data RAM with combinational reads and an image loader that holds
// the processor in reset (cpu_rst) until the program has been streamed in.
module proc_memory #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_out,
    input  logic              we,
    output logic [31:0]       mem_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              ld_start,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   ld_count,
    output logic              err_oob
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]       ram [DEPTH];
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W-1:0] pc_idx, ma_idx;
    logic              pc_oob, ma_oob;
    logic              ld_hs, st_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;

    assign pc_idx = pc[ADDR_W-1:0];
    assign ma_idx = mem_addr[ADDR_W-1:0];
    assign pc_oob = |pc[31:ADDR_W];
    assign ma_oob = |mem_addr[31:ADDR_W];

    // Out-of-range reads return zero rather than an aliased word.
    assign inst   = pc_oob ? '0 : ram[pc_idx];
    assign mem_in = ma_oob ? '0 : ram[ma_idx];

    assign ld_hs = (state == LOAD) && ld_valid && ld_ready;
    assign st_en = (state == RUN) && we && !ma_oob;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (ld_hs && (ld_last || (&ld_ptr))) state_nxt = RELEASE;
            RELEASE: state_nxt = RUN;
            RUN:     if (ld_start) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Loader and processor never write in the same state, so one write port suffices.
    always_comb begin
        wr_en   = ld_hs || st_en;
        wr_idx  = ld_hs ? ld_ptr  : ma_idx;
        wr_data = ld_hs ? ld_data : mem_out;
    end

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            ld_ptr   <= '0;
            ld_count <= '0;
            cpu_rst  <= 1'b1;
            ld_ready <= 1'b0;
            err_oob  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cpu_rst  <= (state_nxt != RUN);
            ld_ready <= (state_nxt == LOAD);
            if (ld_hs) begin
                ld_ptr <= ld_ptr + 1'b1;
                if (ld_count != (ADDR_W+1)'(DEPTH)) ld_count <= ld_count + 1'b1;
            end
            if (state == RUN) begin
                if (ld_start) begin
                    ld_ptr   <= '0;
                    ld_count <= '0;
                    err_oob  <= 1'b0;
                end else if (pc_oob || ma_oob) begin
                    err_oob  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_proc_memory.sv
// Scoreboard bench for proc_memory: a full-size instance (ADDR_W=10) and a
// small instance (ADDR_W=4) for the image-overflow case.
module tb_proc_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, ld_valid, ld_last, ld_start;
    logic [31:0] pc, mem_addr, mem_out, ld_data;
    logic [31:0] inst, mem_in;
    logic        ld_ready, cpu_rst, err_oob;
    logic [10:0] ld_count;

    logic        s_rst, s_we, s_ld_valid, s_ld_last, s_ld_start;
    logic [31:0] s_pc, s_mem_addr, s_mem_out, s_ld_data;
    logic [31:0] s_inst, s_mem_in;
    logic        s_ld_ready, s_cpu_rst, s_err_oob;
    logic [4:0]  s_ld_count;

    proc_memory #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .mem_addr(mem_addr),
        .mem_out(mem_out), .we(we), .mem_in(mem_in), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .ld_start(ld_start), .cpu_rst(cpu_rst), .ld_count(ld_count), .err_oob(err_oob)
    );

    proc_memory #(.ADDR_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .pc(s_pc), .inst(s_inst), .mem_addr(s_mem_addr),
        .mem_out(s_mem_out), .we(s_we), .mem_in(s_mem_in), .ld_valid(s_ld_valid),
        .ld_ready(s_ld_ready), .ld_data(s_ld_data), .ld_last(s_ld_last),
        .ld_start(s_ld_start), .cpu_rst(s_cpu_rst), .ld_count(s_ld_count), .err_oob(s_err_oob)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", got, ~got);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, got, e.v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_word(input logic [31:0] d, input logic last);
        int n;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        n = 0;
        while (!ld_ready && n < 50) begin
            tick();
            n++;
        end
        if (!ld_ready) check("ld_ready_timeout", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    logic [31:0] img [4];
    int accepted;

    initial begin
        rst = 1'b1; we = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        pc = '0; mem_addr = '0; mem_out = '0; ld_data = '0;
        s_rst = 1'b1; s_we = 1'b0; s_ld_valid = 1'b0; s_ld_last = 1'b0; s_ld_start = 1'b0;
        s_pc = '0; s_mem_addr = '0; s_mem_out = '0; s_ld_data = '0;
        repeat (2) tick();

        // reset state
        expect_val("rst_cpu_rst", 32'd1);  observe({31'b0, cpu_rst});
        expect_val("rst_ld_ready", 32'd0); observe({31'b0, ld_ready});
        expect_val("rst_ld_count", 32'd0); observe({21'b0, ld_count});
        expect_val("rst_err_oob", 32'd0);  observe({31'b0, err_oob});
        rst = 1'b0;
        tick();
        expect_val("ready_after_rst", 32'd1); observe({31'b0, ld_ready});

        // 3-word image with an ld_start pulse in a valid gap
        ld_word(32'h11, 1'b0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_val("gap_count", 32'd1); observe({21'b0, ld_count});
        ld_word(32'h22, 1'b0);
        ld_word(32'h33, 1'b1);
        expect_val("img3_count", 32'd3);      observe({21'b0, ld_count});
        expect_val("img3_ready_drop", 32'd0); observe({31'b0, ld_ready});
        expect_val("img3_release_rst", 32'd1); observe({31'b0, cpu_rst});
        tick();
        expect_val("img3_run_rst", 32'd0);    observe({31'b0, cpu_rst});
        expect_val("img3_count_run", 32'd3);  observe({21'b0, ld_count});
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i);
            expect_val($sformatf("inst_pc%0d", i), img[i]);
            #1 observe(inst);
        end
        pc = '0;

        // stores, old value visible in the write cycle
        mem_addr = 32'd5; mem_out = 32'h12345678; we = 1'b1;
        tick();
        mem_out = 32'hDEADBEEF;
        expect_val("store_old_val", 32'h12345678);
        #1 observe(mem_in);
        tick();
        we = 1'b0;
        expect_val("store_new_val", 32'hDEADBEEF);
        #1 observe(mem_in);
        pc = 32'd5;
        expect_val("inst_after_store", 32'hDEADBEEF);
        #1 observe(inst);
        pc = '0;

        // out-of-range store
        mem_addr = 32'h400; mem_out = 32'hBAD0BAD0; we = 1'b1;
        expect_val("oob_read_zero", 32'd0);
        #1 observe(mem_in);
        expect_val("oob_err_before", 32'd0); observe({31'b0, err_oob});
        tick();
        we = 1'b0; mem_addr = '0;
        expect_val("oob_err_set", 32'd1); observe({31'b0, err_oob});
        expect_val("oob_no_alias", 32'h11);
        #1 observe(mem_in);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_val("reload_err_clr", 32'd0);  observe({31'b0, err_oob});
        expect_val("reload_cpu_rst", 32'd1);  observe({31'b0, cpu_rst});
        expect_val("reload_ready", 32'd1);    observe({31'b0, ld_ready});
        expect_val("reload_count", 32'd0);    observe({21'b0, ld_count});

        // processor store attempts while loading, then reset mid-load
        we = 1'b1; mem_addr = 32'd5; mem_out = 32'h0;
        ld_word(32'hA0, 1'b0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        expect_val("load_start_ign", 32'd1); observe({21'b0, ld_count});
        ld_word(32'hA1, 1'b0);
        expect_val("mid_count", 32'd2); observe({21'b0, ld_count});
        rst = 1'b1;
        #1;
        expect_val("midrst_count", 32'd0); observe({21'b0, ld_count});
        expect_val("midrst_ready", 32'd0); observe({31'b0, ld_ready});
        expect_val("midrst_cpu_rst", 32'd1); observe({31'b0, cpu_rst});
        tick();
        rst = 1'b0;
        we = 1'b0;
        img[0] = 32'hA0; img[1] = 32'hA1; img[2] = 32'hA2; img[3] = 32'hA3;
        ld_word(img[0], 1'b0);
        ld_word(img[1], 1'b0);
        tick();
        ld_word(img[2], 1'b0);
        ld_word(img[3], 1'b1);
        expect_val("img4_count", 32'd4); observe({21'b0, ld_count});
        tick();
        expect_val("img4_run_rst", 32'd0); observe({31'b0, cpu_rst});
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i);
            expect_val($sformatf("inst4_pc%0d", i), img[i]);
            #1 observe(inst);
        end
        mem_addr = 32'd5;
        expect_val("load_store_ignored", 32'hDEADBEEF);
        #1 observe(mem_in);

        // out-of-range fetch
        pc = 32'h400;
        expect_val("pc_oob_inst", 32'd0);
        #1 observe(inst);
        tick();
        pc = '0;
        expect_val("pc_oob_err", 32'd1); observe({31'b0, err_oob});

        // full image without ld_last on the small instance
        s_rst = 1'b0;
        s_ld_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            s_ld_data = 32'h100 + 32'(accepted);
            if (s_ld_ready) accepted++;
            tick();
        end
        s_ld_valid = 1'b0;
        expect_val("full_accepted", 32'd16); observe(32'(accepted));
        expect_val("full_count", 32'd16);    observe({27'b0, s_ld_count});
        expect_val("full_ready", 32'd0);     observe({31'b0, s_ld_ready});
        expect_val("full_run", 32'd0);       observe({31'b0, s_cpu_rst});
        for (int i = 0; i < 16; i += 5) begin
            s_pc = 32'(i);
            expect_val($sformatf("full_inst%0d", i), 32'h100 + 32'(i));
            #1 observe(s_inst);
        end

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
